// File: rtl/rv32i_dbg_pkg.sv
// Shared debug-checker definitions: state encoding (also decoded by the system top
// for the HEX display) and the default PC width.
package rv32i_dbg_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_history_buf.sv
// Circular buffer of the most recent retired PCs, read combinationally with
// index 0 as the newest entry. Cleared only by its synchronous clear input.
module pc_history_buf import rv32i_dbg_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned HIST = 8,
  localparam int unsigned PW  = $clog2(HIST)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  input  logic [PW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] hist_q [HIST];
  logic [XLEN-1:0] hist_d [HIST];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr;

  // Write the new PC at the write pointer, then advance it (wraps mod HIST).
  always_comb begin
    hist_d = hist_q;
    wptr_d = wptr_q;
    if (we) begin
      hist_d[wptr_q] = wdata;
      wptr_d         = wptr_q + PW'(1);
    end
  end

  // Newest entry sits one slot behind the write pointer.
  always_comb begin
    rptr    = wptr_q - PW'(1) - rd_idx;
    rd_data = hist_q[rptr];
  end

  // Buffer storage and pointer with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      hist_q <= '{default: '0};
      wptr_q <= '0;
    end else begin
      hist_q <= hist_d;
      wptr_q <= wptr_d;
    end
  end

endmodule

// File: rtl/retire_trace_checker.sv
// Retire-stream checker: compares each retired {pc,inst} in order against a golden
// table, reports pass / mismatch / hang, and keeps a short PC history for debug.
// The golden table is supplied as a packed parameter, entry i at bits [i*(XLEN+32) +: XLEN+32].
module retire_trace_checker import rv32i_dbg_pkg::*; #(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned HIST    = 8,
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [DEPTH*(XLEN+32)-1:0] GOLDEN = '0,
  localparam int unsigned IW = $clog2(DEPTH),
  localparam int unsigned HW = $clog2(HIST)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_pc,
  input  logic [31:0]     retire_inst,
  input  logic [HW-1:0]   hist_idx,
  output logic [XLEN-1:0] hist_pc,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            hang,
  output logic [IW-1:0]   err_idx,
  output logic [XLEN-1:0] err_pc,
  output logic [31:0]     err_inst,
  output logic [31:0]     retire_cnt
);

  localparam int unsigned EW = XLEN + 32;
  localparam int unsigned TW = $clog2(TIMEOUT);

  logic [EW-1:0]   rom [DEPTH];
  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [IW-1:0]   err_idx_q, err_idx_d;
  logic [XLEN-1:0] err_pc_q, err_pc_d;
  logic [31:0]     err_inst_q, err_inst_d;
  logic            hang_q, hang_d;
  logic            match;
  logic            hist_we;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = GOLDEN[g*EW +: EW];
  end

  assign match   = ({retire_pc, retire_inst} == rom[idx_q]);
  assign hist_we = (state_q == ST_RUN) && retire_valid;

  // Checker FSM: arm on start, step through the golden table, stop on pass/fail/hang.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    err_idx_d  = err_idx_q;
    err_pc_d   = err_pc_q;
    err_inst_d = err_inst_q;
    hang_d     = hang_q;
    unique case (state_q)
      ST_RUN: begin
        // A retire in the timeout cycle takes priority over the hang.
        if (retire_valid) begin
          timer_d = '0;
          cnt_d   = sat_inc(cnt_q);
          if (!match) begin
            state_d    = ST_FAIL;
            err_idx_d  = idx_q;
            err_pc_d   = retire_pc;
            err_inst_d = retire_inst;
            hang_d     = 1'b0;
          end else if (idx_q == IW'(DEPTH - 1)) begin
            state_d = ST_PASS;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d   = ST_FAIL;
          hang_d    = 1'b1;
          err_idx_d = idx_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        if (start) begin
          state_d    = ST_RUN;
          idx_d      = '0;
          timer_d    = '0;
          cnt_d      = '0;
          err_idx_d  = '0;
          err_pc_d   = '0;
          err_inst_d = '0;
          hang_d     = 1'b0;
        end
      end
    endcase
  end

  // Status and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      err_idx_q  <= '0;
      err_pc_q   <= '0;
      err_inst_q <= '0;
      hang_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      err_idx_q  <= err_idx_d;
      err_pc_q   <= err_pc_d;
      err_inst_q <= err_inst_d;
      hang_q     <= hang_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign pass       = (state_q == ST_PASS);
  assign fail       = (state_q == ST_FAIL);
  assign done       = pass || fail;
  assign hang       = hang_q;
  assign err_idx    = err_idx_q;
  assign err_pc     = err_pc_q;
  assign err_inst   = err_inst_q;
  assign retire_cnt = cnt_q;

  pc_history_buf #(
    .XLEN (XLEN),
    .HIST (HIST)
  ) u_hist (
    .clk     (clk),
    .clr     (reset),
    .we      (hist_we),
    .wdata   (retire_pc),
    .rd_idx  (hist_idx),
    .rd_data (hist_pc)
  );

endmodule

// File: tb/tb_retire_trace_checker.sv
// Directed bench for retire_trace_checker: expectations are queued before each
// stimulus step and popped/compared once the DUT has responded.
module tb_retire_trace_checker;

  localparam logic [31:0] PC4 [4] = '{32'h100, 32'h104, 32'h108, 32'h10c};
  localparam logic [31:0] IN4 [4] = '{32'h00500093, 32'h00a00113, 32'hfe042623, 32'h002081b3};
  localparam logic [4*64-1:0] G4 = {PC4[3], IN4[3], PC4[2], IN4[2],
                                    PC4[1], IN4[1], PC4[0], IN4[0]};

  localparam logic [31:0] PC8 [8] = '{32'h200, 32'h204, 32'h208, 32'h20c,
                                      32'h210, 32'h214, 32'h218, 32'h21c};
  localparam logic [31:0] IN8 [8] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213,
                                      32'h00500293, 32'h00600313, 32'h00700393, 32'h00800413};
  localparam logic [8*64-1:0] G8 = {PC8[7], IN8[7], PC8[6], IN8[6], PC8[5], IN8[5], PC8[4], IN8[4],
                                    PC8[3], IN8[3], PC8[2], IN8[2], PC8[1], IN8[1], PC8[0], IN8[0]};

  logic        clk = 1'b0;
  logic        reset, start, retire_valid;
  logic [31:0] retire_pc, retire_inst;
  logic [1:0]  hist_idx;

  logic [31:0] hist_pc, err_pc, err_inst, retire_cnt;
  logic        busy, done, pass, fail, hang;
  logic [1:0]  err_idx;

  logic [31:0] hist_pc8, err_pc8, err_inst8, retire_cnt8;
  logic        busy8, done8, pass8, fail8, hang8;
  logic [2:0]  err_idx8;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  retire_trace_checker #(
    .XLEN (32), .DEPTH (4), .HIST (4), .TIMEOUT (16), .GOLDEN (G4)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .retire_valid (retire_valid),
    .retire_pc (retire_pc), .retire_inst (retire_inst), .hist_idx (hist_idx),
    .hist_pc (hist_pc), .busy (busy), .done (done), .pass (pass), .fail (fail),
    .hang (hang), .err_idx (err_idx), .err_pc (err_pc), .err_inst (err_inst),
    .retire_cnt (retire_cnt)
  );

  retire_trace_checker #(
    .XLEN (32), .DEPTH (8), .HIST (4), .TIMEOUT (16), .GOLDEN (G8)
  ) dut8 (
    .clk (clk), .reset (reset), .start (start), .retire_valid (retire_valid),
    .retire_pc (retire_pc), .retire_inst (retire_inst), .hist_idx (hist_idx),
    .hist_pc (hist_pc8), .busy (busy8), .done (done8), .pass (pass8), .fail (fail8),
    .hang (hang8), .err_idx (err_idx8), .err_pc (err_pc8), .err_inst (err_inst8),
    .retire_cnt (retire_cnt8)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow: observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] inst);
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_inst  = inst;
    step();
    retire_valid = 1'b0;
    retire_pc    = '0;
    retire_inst  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; retire_valid = 1'b0;
    retire_pc = '0; retire_inst = '0; hist_idx = '0;
    step(); step();
    expect_val("rst_busy", 0); expect_val("rst_done", 0);
    expect_val("rst_cnt", 0);  expect_val("rst_hist", 0);
    chk(32'(busy)); chk(32'(done)); chk(retire_cnt); chk(hist_pc);
    reset = 1'b0;

    // 1: full golden run
    pulse_start();
    expect_val("t1_busy", 1);
    chk(32'(busy));
    for (int i = 0; i < 3; i++) begin
      expect_val("t1_pass_early", 0);
      retire(PC4[i], IN4[i]);
      chk(32'(pass));
    end
    expect_val("t1_pass", 1); expect_val("t1_done", 1); expect_val("t1_cnt", 4);
    retire(PC4[3], IN4[3]);
    chk(32'(pass)); chk(32'(done)); chk(retire_cnt);
    expect_val("t1_hist0", PC4[3]);
    hist_idx = 2'd0; #1; chk(hist_pc);
    expect_val("t1_hist3", PC4[0]);
    hist_idx = 2'd3; #1; chk(hist_pc);
    hist_idx = 2'd0;

    // 2: instruction mismatch on the third retire (re-arm from PASS)
    pulse_start();
    expect_val("t2_busy", 1); expect_val("t2_cnt_clr", 0);
    chk(32'(busy)); chk(retire_cnt);
    retire(PC4[0], IN4[0]);
    retire(PC4[1], IN4[1]);
    expect_val("t2_fail", 1); expect_val("t2_hang", 0); expect_val("t2_err_idx", 2);
    expect_val("t2_err_inst", 32'h00000013); expect_val("t2_err_pc", PC4[2]);
    expect_val("t2_cnt", 3);
    retire(PC4[2], 32'h00000013);
    chk(32'(fail)); chk(32'(hang)); chk(32'(err_idx));
    chk(err_inst); chk(err_pc); chk(retire_cnt);

    // 6a: re-arm from FAIL clears error capture
    pulse_start();
    expect_val("t6_busy", 1); expect_val("t6_fail", 0); expect_val("t6_err_idx", 0);
    expect_val("t6_err_pc", 0); expect_val("t6_err_inst", 0);
    chk(32'(busy)); chk(32'(fail)); chk(32'(err_idx)); chk(err_pc); chk(err_inst);

    // 3: timeout; a retire in the timeout cycle wins, start ignored in RUN
    retire(PC4[0], IN4[0]);
    repeat (15) step();
    expect_val("t3_retire_wins_fail", 0); expect_val("t3_retire_wins_busy", 1);
    retire(PC4[1], IN4[1]);
    chk(32'(fail)); chk(32'(busy));
    repeat (14) step();
    pulse_start();
    expect_val("t3_fail_early", 0); expect_val("t3_start_ignored_cnt", 2);
    chk(32'(fail)); chk(retire_cnt);
    expect_val("t3_fail", 1); expect_val("t3_hang", 1); expect_val("t3_err_idx", 2);
    expect_val("t3_err_pc", 0);
    step();
    chk(32'(fail)); chk(32'(hang)); chk(32'(err_idx)); chk(err_pc);

    // 6b: retire_valid in IDLE is ignored
    reset = 1'b1; step(); reset = 1'b0;
    expect_val("t6_idle_cnt", 0); expect_val("t6_idle_busy", 0); expect_val("t6_idle_hist", 0);
    retire(PC4[0], IN4[0]);
    chk(retire_cnt); chk(32'(busy)); chk(hist_pc);

    // 4: reset in the middle of a run
    pulse_start();
    retire(PC4[0], IN4[0]);
    retire(PC4[1], IN4[1]);
    expect_val("t4_busy_pre", 1); expect_val("t4_cnt_pre", 2);
    chk(32'(busy)); chk(retire_cnt);
    reset = 1'b1;
    step();
    expect_val("t4_busy", 0); expect_val("t4_cnt", 0);
    chk(32'(busy)); chk(retire_cnt);
    for (int k = 0; k < 4; k++) begin
      expect_val($sformatf("t4_hist%0d", k), 0);
      hist_idx = 2'(k); #1; chk(hist_pc);
    end
    hist_idx = 2'd0;
    reset = 1'b0;

    // 5: history wrap on the DEPTH=8 instance
    pulse_start();
    for (int k = 0; k < 6; k++) retire(PC8[k], IN8[k]);
    expect_val("t5_busy", 1); expect_val("t5_fail", 0); expect_val("t5_cnt", 6);
    chk(32'(busy8)); chk(32'(fail8)); chk(retire_cnt8);
    for (int k = 0; k < 4; k++) begin
      expect_val($sformatf("t5_hist%0d", k), PC8[5-k]);
      hist_idx = 2'(k); #1; chk(hist_pc8);
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
